// File: rtl/seg_pkg.sv
// Shared constants and the leading-zero mask helper for the 7-segment scan driver.
package seg_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
    localparam int unsigned MAX_DIGITS = 32;

    typedef logic [DIGIT_W*MAX_DIGITS-1:0] code_vec_t;
    typedef logic [MAX_DIGITS-1:0]         mask_vec_t;

    // Walks down from the top digit; a digit is dark while everything at or above it
    // is a zero without a decimal point. Digit 0 is never included.
    function automatic mask_vec_t lz_mask(input code_vec_t codes, input mask_vec_t dp,
                                          input int unsigned n, input logic en);
        mask_vec_t m;
        logic      zero_run;
        m        = '0;
        zero_run = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i + 1 < n) begin
                zero_run = zero_run && (codes[DIGIT_W*(n-1-i) +: DIGIT_W] == '0) && !dp[n-1-i];
                m[n-1-i] = zero_run && en;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Load-side frame bus and display-side scan outputs of seg_scan.
interface seg_scan_if #(
    parameter int unsigned DIGITS = 8
);
    import seg_pkg::*;

    logic                        load;
    logic [DIGIT_W*DIGITS-1:0]   digits_in;
    logic [DIGITS-1:0]           dp_in_mask;
    logic [DIGITS-1:0]           blank_mask;
    logic [DIGITS-1:0]           blink_mask;
    logic [DIGIT_W-1:0]          num;
    logic                        dp;
    logic [DIGITS-1:0]           digit_sel;
    logic                        frame_start;

    modport master (
        output load, digits_in, dp_in_mask, blank_mask, blink_mask,
        input  num, dp, digit_sel, frame_start
    );

    modport slave (
        input  load, digits_in, dp_in_mask, blank_mask, blink_mask,
        output num, dp, digit_sel, frame_start
    );

endinterface

// File: rtl/seg_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every SCAN_DIV clocks.
module seg_tick_gen #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 7-segment scan driver with double-buffered frames,
// leading-zero suppression, per-digit blanking and blink.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 250,
    parameter int unsigned LZ_BLANK     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BC_W  = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned CODE_W = DIGIT_W * DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [BC_W-1:0]  BLINK_LAST = BC_W'(BLINK_FRAMES - 1);

    logic tick;

    seg_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               dead_q, dead_d;
    logic [CODE_W-1:0]  pend_code_q, pend_code_d;
    logic [DIGITS-1:0]  pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]  pend_blank_q, pend_blank_d;
    logic [DIGITS-1:0]  pend_blink_q, pend_blink_d;
    logic               pend_valid_q, pend_valid_d;
    logic [CODE_W-1:0]  act_code_q, act_code_d;
    logic [DIGITS-1:0]  act_dp_q, act_dp_d;
    logic [DIGITS-1:0]  act_blank_q, act_blank_d;
    logic [DIGITS-1:0]  act_blink_q, act_blink_d;
    logic [DIGITS-1:0]  act_lz_q, act_lz_d;
    logic [BC_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [DIGIT_W-1:0] num_q, num_d;
    logic               dp_q, dp_d;
    logic [DIGITS-1:0]  sel_q, sel_d;
    logic               fs_q, fs_d;

    logic               wrap;
    logic               eff_blank;
    logic [CODE_W-1:0]  src_code;
    logic [DIGITS-1:0]  src_dp;

    always_comb begin
        idx_d         = idx_q;
        dead_d        = tick;
        pend_code_d   = pend_code_q;
        pend_dp_d     = pend_dp_q;
        pend_blank_d  = pend_blank_q;
        pend_blink_d  = pend_blink_q;
        pend_valid_d  = pend_valid_q;
        act_code_d    = act_code_q;
        act_dp_d      = act_dp_q;
        act_blank_d   = act_blank_q;
        act_blink_d   = act_blink_q;
        act_lz_d      = act_lz_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        num_d         = BLANK_CODE;
        dp_d          = 1'b0;
        sel_d         = '1;
        fs_d          = 1'b0;
        eff_blank     = 1'b0;

        wrap     = tick && (idx_q == LAST_IDX);
        src_code = bus.load ? bus.digits_in  : pend_code_q;
        src_dp   = bus.load ? bus.dp_in_mask : pend_dp_q;

        if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

        if (bus.load) begin
            pend_code_d  = bus.digits_in;
            pend_dp_d    = bus.dp_in_mask;
            pend_blank_d = bus.blank_mask;
            pend_blink_d = bus.blink_mask;
            pend_valid_d = 1'b1;
        end

        // A load landing on the wrap tick bypasses the pending buffer straight into the frame.
        if (wrap) begin
            if (bus.load || pend_valid_q) begin
                act_code_d  = src_code;
                act_dp_d    = src_dp;
                act_blank_d = bus.load ? bus.blank_mask : pend_blank_q;
                act_blink_d = bus.load ? bus.blink_mask : pend_blink_q;
                act_lz_d    = DIGITS'(lz_mask(code_vec_t'(src_code), mask_vec_t'(src_dp),
                                              DIGITS, LZ_BLANK != 0));
            end
            pend_valid_d = 1'b0;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 1'b1;
            end
        end

        // The cycle after a tick is dead time; otherwise present the current slot.
        if (!tick) begin
            eff_blank = act_blank_q[idx_q] | (act_blink_q[idx_q] & blink_phase_q) | act_lz_q[idx_q];
            num_d     = eff_blank ? BLANK_CODE : act_code_q[idx_q*DIGIT_W +: DIGIT_W];
            dp_d      = act_dp_q[idx_q] & ~eff_blank;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                sel_d[i] = (IDX_W'(i) != idx_q);
            end
            fs_d      = dead_q && (idx_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            dead_q        <= 1'b1;
            pend_code_q   <= '1;
            pend_dp_q     <= '0;
            pend_blank_q  <= '0;
            pend_blink_q  <= '0;
            pend_valid_q  <= 1'b0;
            act_code_q    <= '1;
            act_dp_q      <= '0;
            act_blank_q   <= '0;
            act_blink_q   <= '0;
            act_lz_q      <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            num_q         <= BLANK_CODE;
            dp_q          <= 1'b0;
            sel_q         <= '1;
            fs_q          <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            dead_q        <= dead_d;
            pend_code_q   <= pend_code_d;
            pend_dp_q     <= pend_dp_d;
            pend_blank_q  <= pend_blank_d;
            pend_blink_q  <= pend_blink_d;
            pend_valid_q  <= pend_valid_d;
            act_code_q    <= act_code_d;
            act_dp_q      <= act_dp_d;
            act_blank_q   <= act_blank_d;
            act_blink_q   <= act_blink_d;
            act_lz_q      <= act_lz_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            num_q         <= num_d;
            dp_q          <= dp_d;
            sel_q         <= sel_d;
            fs_q          <= fs_d;
        end
    end

    assign bus.num         = num_q;
    assign bus.dp          = dp_q;
    assign bus.digit_sel   = sel_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: directed and random frame loads against a cycle-count reference model.
module tb_seg_scan;

    typedef struct packed {
        logic [15:0] code;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
    } frame_t;

    localparam frame_t RESET_FRAME = '{code: 16'hFFFF, dp: 4'h0, blank: 4'h0, blink: 4'h0};

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   k;
    frame_t cur;
    frame_t pend;
    bit     pv;

    seg_scan_if #(.DIGITS(4)) bus ();

    seg_scan #(
        .DIGITS       (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2),
        .LZ_BLANK     (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a digit is dark if blanked, blinking in the off phase, or above the most significant non-zero/dp digit.
    function automatic bit hidden(frame_t f, int d, bit ph);
        int msd;
        msd = 0;
        for (int j = 0; j < 4; j++)
            if (f.code[4*j +: 4] != 4'h0 || f.dp[j]) msd = j;
        return f.blank[d] || (f.blink[d] && ph) || (d > msd);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int  pos, d, fr;
        bit  ph, hid;
        logic [3:0] e_sel, e_num;
        logic       e_dp, e_fs;
        pos = k % 4;
        d   = (k / 4) % 4;
        fr  = k / 16;
        ph  = ((fr / 2) % 2) == 1;
        if (pos == 0) begin
            e_sel = 4'hF; e_num = 4'hF; e_dp = 1'b0; e_fs = 1'b0;
        end else begin
            hid   = hidden(cur, d, ph);
            e_sel = ~(4'h1 << d);
            e_num = hid ? 4'hF : cur.code[4*d +: 4];
            e_dp  = cur.dp[d] && !hid;
            e_fs  = (d == 0) && (pos == 1);
        end
        chk("digit_sel", {12'h0, bus.digit_sel}, {12'h0, e_sel});
        chk("num", {12'h0, bus.num}, {12'h0, e_num});
        chk("dp", {15'h0, bus.dp}, {15'h0, e_dp});
        chk("frame_start", {15'h0, bus.frame_start}, {15'h0, e_fs});
    endtask

    task automatic cyc();
        frame_t in_f;
        @(posedge clk);
        in_f = '{code: bus.digits_in, dp: bus.dp_in_mask, blank: bus.blank_mask, blink: bus.blink_mask};
        if (k % 16 == 15) begin
            if (bus.load) cur = in_f;
            else if (pv)  cur = pend;
            pv = 1'b0;
        end else if (bus.load) begin
            pend = in_f;
            pv   = 1'b1;
        end
        k++;
        #1;
        check_outputs();
        bus.load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic run_to(input int m);
        cyc();
        while (k % 16 != m) cyc();
    endtask

    task automatic set_load(input logic [15:0] code, input logic [3:0] dpm,
                            input logic [3:0] blk, input logic [3:0] bln);
        bus.load       = 1'b1;
        bus.digits_in  = code;
        bus.dp_in_mask = dpm;
        bus.blank_mask = blk;
        bus.blink_mask = bln;
    endtask

    task automatic model_reset();
        k    = 0;
        cur  = RESET_FRAME;
        pend = RESET_FRAME;
        pv   = 1'b0;
    endtask

    initial begin
        logic [15:0] rc;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.load = 1'b0;
        bus.digits_in = '0;
        bus.dp_in_mask = '0;
        bus.blank_mask = '0;
        bus.blink_mask = '0;
        model_reset();

        #12;
        chk("rst_sel", {12'h0, bus.digit_sel}, 16'h000F);
        chk("rst_num", {12'h0, bus.num}, 16'h000F);
        chk("rst_dp", {15'h0, bus.dp}, 16'h0000);
        chk("rst_fs", {15'h0, bus.frame_start}, 16'h0000);
        #10;
        rst_n = 1'b1;

        // Idle scan with blank content.
        run(32);

        // Mid-frame load with leading zeros.
        run_to(5);
        set_load(16'h0057, 4'b0000, 4'b0000, 4'b0000);
        run(40);

        // Decimal point on the top digit defeats zero suppression.
        set_load(16'h0057, 4'b1000, 4'b0000, 4'b0000);
        run(40);

        // All zeros: only digit 0 stays lit.
        set_load(16'h0000, 4'b0000, 4'b0000, 4'b0000);
        run(36);

        // Blinking digit 0 over several frames.
        set_load(16'h1234, 4'b0000, 4'b0000, 4'b0001);
        run(90);

        // Pending 1234 overtaken by a load on the wrap tick.
        run_to(5);
        set_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        run_to(15);
        set_load(16'h9876, 4'b0000, 4'b0000, 4'b0000);
        run(40);

        // Forced blanking mask.
        set_load(16'h4321, 4'b0101, 4'b0110, 4'b0000);
        run(36);

        // Randomized loads.
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int j = 0; j < 4; j++)
                    rc[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                set_load(rc, 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                         4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                         4'($urandom_range(0, 15)));
            end
            cyc();
        end

        // Asynchronous reset in the digit 2 slot.
        set_load(16'h5555, 4'b0000, 4'b0000, 4'b0000);
        run(20);
        run_to(9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", {12'h0, bus.digit_sel}, 16'h000F);
        chk("arst_num", {12'h0, bus.num}, 16'h000F);
        chk("arst_dp", {15'h0, bus.dp}, 16'h0000);
        chk("arst_fs", {15'h0, bus.frame_start}, 16'h0000);
        #2;
        rst_n = 1'b1;
        model_reset();
        run(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
